// File: rtl/key_bank_pkg.sv
// Shared types and sizing helpers for the key bank and its compare array.
package key_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int DEF_KEY_W    = 8;
    localparam int DEF_MAX_KEYS = 4;

    // Ceiling log2, never below 1 so single-entry banks still get a 1-bit field.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/key_cam_cmp.sv
// Combinational compare of one operand against every slot of the bank.
// Reports a hit and the lowest matching slot index (0 when nothing matches).
module key_cam_cmp #(
    parameter int KEY_W    = 8,
    parameter int MAX_KEYS = 4,
    parameter int IDX_W    = 2
) (
    input  logic [KEY_W-1:0]          operand_i,
    input  logic [MAX_KEYS*KEY_W-1:0] slots_i,
    input  logic [MAX_KEYS-1:0]       valid_i,
    output logic                      hit_o,
    output logic [IDX_W-1:0]          idx_o
);

    logic [MAX_KEYS-1:0] eq;

    for (genvar gi = 0; gi < MAX_KEYS; gi++) begin : g_eq
        assign eq[gi] = valid_i[gi] && (slots_i[gi*KEY_W +: KEY_W] == operand_i);
    end

    // Scan from the top down so the lowest matching slot is the last assignment.
    always_comb begin
        hit_o = |eq;
        idx_o = '0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (eq[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_bank.sv
// Serially loaded key bank with load/lock sessions and a one-cycle lookup port.
// Optional duplicate-write filter: define KEY_BANK_DUP_FILTER_EN.
module key_bank
    import key_bank_pkg::*;
#(
    parameter  int KEY_W     = DEF_KEY_W,
    parameter  int MAX_KEYS  = DEF_MAX_KEYS,
    parameter  int WRAP_MODE = 0,
    localparam int CNT_W     = clog2_min1(MAX_KEYS + 1),
    localparam int IDX_W     = clog2_min1(MAX_KEYS)
) (
    input  logic                      dclk,
    input  logic                      reset_n,
    input  logic [KEY_W-1:0]          din,
    input  logic                      kset,
    input  logic [KEY_W-1:0]          qry_din,
    input  logic                      qry_valid,
    output logic [CNT_W-1:0]          num_keys,
    output logic [MAX_KEYS*KEY_W-1:0] keys,
    output logic                      keys_valid,
    output logic                      full,
    output logic                      overflow,
    output logic                      match_valid,
    output logic                      match_hit,
    output logic [IDX_W-1:0]          match_idx
);

    state_e               state_q, state_d;
    logic [KEY_W-1:0]     slots_q [MAX_KEYS];
    logic [KEY_W-1:0]     slots_d [MAX_KEYS];
    logic [CNT_W-1:0]     num_keys_q, num_keys_d;
    logic [IDX_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                 overflow_q, overflow_d;
    logic                 match_valid_q;
    logic                 match_hit_q;
    logic [IDX_W-1:0]     match_idx_q;

    logic [MAX_KEYS*KEY_W-1:0] slots_flat;
    logic [MAX_KEYS-1:0]       valid_mask;
    logic                      full_w;
    logic                      qry_hit;
    logic [IDX_W-1:0]          qry_idx;
    logic                      dup_hit;
    logic                      do_write;
    logic                      clear_all;
    logic [IDX_W-1:0]          wr_idx;

    for (genvar gi = 0; gi < MAX_KEYS; gi++) begin : g_slot
        assign slots_flat[gi*KEY_W +: KEY_W] = slots_q[gi];
        assign valid_mask[gi]                = (32'(gi) < 32'(num_keys_q));
    end

    assign full_w = (32'(num_keys_q) == MAX_KEYS);

    key_cam_cmp #(
        .KEY_W    (KEY_W),
        .MAX_KEYS (MAX_KEYS),
        .IDX_W    (IDX_W)
    ) u_qry_cmp (
        .operand_i (qry_din),
        .slots_i   (slots_flat),
        .valid_i   (valid_mask),
        .hit_o     (qry_hit),
        .idx_o     (qry_idx)
    );

`ifdef KEY_BANK_DUP_FILTER_EN
    logic [IDX_W-1:0] dup_idx;

    key_cam_cmp #(
        .KEY_W    (KEY_W),
        .MAX_KEYS (MAX_KEYS),
        .IDX_W    (IDX_W)
    ) u_dup_cmp (
        .operand_i (din),
        .slots_i   (slots_flat),
        .valid_i   (valid_mask),
        .hit_o     (dup_hit),
        .idx_o     (dup_idx)
    );
`else
    assign dup_hit = 1'b0;
`endif

    // Non-wrapping banks park the pointer on the last slot; it is never used once full.
    function automatic logic [IDX_W-1:0] ptr_adv(input logic [IDX_W-1:0] p);
        if (32'(p) >= MAX_KEYS - 1) begin
            return (WRAP_MODE != 0) ? '0 : p;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        num_keys_d = num_keys_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        do_write   = 1'b0;
        clear_all  = 1'b0;
        wr_idx     = '0;

        case (state_q)
            ST_IDLE: begin
                if (kset) begin
                    do_write   = 1'b1;
                    num_keys_d = CNT_W'(1);
                    wr_ptr_d   = ptr_adv('0);
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!kset) begin
                    state_d = ST_LOCKED;
                end else if (!dup_hit) begin
                    if (!full_w) begin
                        do_write   = 1'b1;
                        wr_idx     = wr_ptr_q;
                        wr_ptr_d   = ptr_adv(wr_ptr_q);
                        num_keys_d = num_keys_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                        if (WRAP_MODE != 0) begin
                            do_write = 1'b1;
                            wr_idx   = wr_ptr_q;
                            wr_ptr_d = ptr_adv(wr_ptr_q);
                        end
                    end
                end
            end
            ST_LOCKED: begin
                // Clear and first write land on the same edge: no empty-bank cycle.
                if (kset) begin
                    clear_all  = 1'b1;
                    do_write   = 1'b1;
                    num_keys_d = CNT_W'(1);
                    wr_ptr_d   = ptr_adv('0);
                    overflow_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int i = 0; i < MAX_KEYS; i++) begin
            slots_d[i] = clear_all ? '0 : slots_q[i];
            if (do_write && (32'(wr_idx) == i)) begin
                slots_d[i] = din;
            end
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            num_keys_q    <= '0;
            wr_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            match_valid_q <= 1'b0;
            match_hit_q   <= 1'b0;
            match_idx_q   <= '0;
            for (int i = 0; i < MAX_KEYS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            num_keys_q    <= num_keys_d;
            wr_ptr_q      <= wr_ptr_d;
            overflow_q    <= overflow_d;
            match_valid_q <= qry_valid;
            if (qry_valid) begin
                match_hit_q <= qry_hit;
                match_idx_q <= qry_idx;
            end
            for (int i = 0; i < MAX_KEYS; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    assign num_keys    = num_keys_q;
    assign keys        = slots_flat;
    assign keys_valid  = (state_q == ST_LOCKED);
    assign full        = full_w;
    assign overflow    = overflow_q;
    assign match_valid = match_valid_q;
    assign match_hit   = match_hit_q;
    assign match_idx   = match_idx_q;

endmodule

// File: tb/tb_key_bank.sv
// Directed, table-driven bench for key_bank: default bank, ring-mode bank and single-key bank.
module tb_key_bank;

    logic        dclk;
    logic        reset_n;
    logic [7:0]  din, qry_din;
    logic        kset, qry_valid;
    logic [2:0]  num_keys;
    logic [31:0] keys;
    logic        keys_valid, full, overflow, match_valid, match_hit;
    logic [1:0]  match_idx;

    logic [7:0]  w_din;
    logic        w_kset;
    logic [2:0]  w_num;
    logic [31:0] w_keys;
    logic        w_kv, w_full, w_ovf, w_mv, w_mh;
    logic [1:0]  w_mi;

    logic [7:0]  o_din;
    logic        o_kset;
    logic [0:0]  o_num;
    logic [7:0]  o_keys;
    logic        o_kv, o_full, o_ovf, o_mv, o_mh;
    logic [0:0]  o_mi;

    int total = 0;
    int bad   = 0;

    key_bank dut (
        .dclk(dclk), .reset_n(reset_n), .din(din), .kset(kset),
        .qry_din(qry_din), .qry_valid(qry_valid), .num_keys(num_keys), .keys(keys),
        .keys_valid(keys_valid), .full(full), .overflow(overflow),
        .match_valid(match_valid), .match_hit(match_hit), .match_idx(match_idx)
    );

    key_bank #(.WRAP_MODE(1)) dut_wrap (
        .dclk(dclk), .reset_n(reset_n), .din(w_din), .kset(w_kset),
        .qry_din(8'h00), .qry_valid(1'b0), .num_keys(w_num), .keys(w_keys),
        .keys_valid(w_kv), .full(w_full), .overflow(w_ovf),
        .match_valid(w_mv), .match_hit(w_mh), .match_idx(w_mi)
    );

    key_bank #(.MAX_KEYS(1)) dut_one (
        .dclk(dclk), .reset_n(reset_n), .din(o_din), .kset(o_kset),
        .qry_din(8'h00), .qry_valid(1'b0), .num_keys(o_num), .keys(o_keys),
        .keys_valid(o_kv), .full(o_full), .overflow(o_ovf),
        .match_valid(o_mv), .match_hit(o_mh), .match_idx(o_mi)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    typedef struct {
        logic        kset;
        logic [7:0]  din;
        logic        qv;
        logic [7:0]  qd;
        logic [2:0]  e_num;
        logic [31:0] e_keys;
        logic        e_full, e_ovf, e_kv, e_mv, e_mh;
        logic [1:0]  e_mi;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic k, input logic [7:0] d, input logic qv,
                                input logic [7:0] qd, input logic [2:0] n,
                                input logic [31:0] kk, input logic fu, input logic ov,
                                input logic kv, input logic mv, input logic mh,
                                input logic [1:0] mi);
        vec_t v;
        v.kset = k;  v.din = d;  v.qv = qv;  v.qd = qd;
        v.e_num = n; v.e_keys = kk; v.e_full = fu; v.e_ovf = ov;
        v.e_kv = kv; v.e_mv = mv; v.e_mh = mh; v.e_mi = mi;
        return v;
    endfunction

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] n, input logic [31:0] kk,
                           input logic fu, input logic ov, input logic kv,
                           input logic mv, input logic mh, input logic [1:0] mi);
        chk({tag, " num_keys"}, 32'(num_keys), 32'(n));
        chk({tag, " keys"}, keys, kk);
        chk({tag, " full"}, 32'(full), 32'(fu));
        chk({tag, " overflow"}, 32'(overflow), 32'(ov));
        chk({tag, " keys_valid"}, 32'(keys_valid), 32'(kv));
        chk({tag, " match_valid"}, 32'(match_valid), 32'(mv));
        chk({tag, " match_hit"}, 32'(match_hit), 32'(mh));
        chk({tag, " match_idx"}, 32'(match_idx), 32'(mi));
    endtask

    initial begin
        //                 kset din   qv  qd     num keys          fu ov kv mv mh mi
        vecs[0]  = mk(0, 8'h00, 1, 8'h00, 3'd0, 32'h00000000, 0, 0, 0, 1, 0, 2'd0);
        vecs[1]  = mk(1, 8'h02, 0, 8'h00, 3'd1, 32'h00000002, 0, 0, 0, 0, 0, 2'd0);
        vecs[2]  = mk(1, 8'h06, 0, 8'h00, 3'd2, 32'h00000602, 0, 0, 0, 0, 0, 2'd0);
        vecs[3]  = mk(1, 8'h0E, 0, 8'h00, 3'd3, 32'h000E0602, 0, 0, 0, 0, 0, 2'd0);
        vecs[4]  = mk(1, 8'h1E, 0, 8'h00, 3'd4, 32'h1E0E0602, 1, 0, 0, 0, 0, 2'd0);
        vecs[5]  = mk(1, 8'h3E, 0, 8'h00, 3'd4, 32'h1E0E0602, 1, 1, 0, 0, 0, 2'd0);
        vecs[6]  = mk(1, 8'h3E, 1, 8'h1E, 3'd4, 32'h1E0E0602, 1, 1, 0, 1, 1, 2'd3);
        vecs[7]  = mk(0, 8'h00, 0, 8'h00, 3'd4, 32'h1E0E0602, 1, 1, 1, 0, 1, 2'd3);
        vecs[8]  = mk(0, 8'h00, 1, 8'h0E, 3'd4, 32'h1E0E0602, 1, 1, 1, 1, 1, 2'd2);
        vecs[9]  = mk(0, 8'h00, 1, 8'h55, 3'd4, 32'h1E0E0602, 1, 1, 1, 1, 0, 2'd0);
        vecs[10] = mk(0, 8'h00, 0, 8'h00, 3'd4, 32'h1E0E0602, 1, 1, 1, 0, 0, 2'd0);
        vecs[11] = mk(1, 8'h3E, 1, 8'h06, 3'd1, 32'h0000003E, 0, 0, 0, 1, 1, 2'd1);
        vecs[12] = mk(0, 8'h00, 0, 8'h00, 3'd1, 32'h0000003E, 0, 0, 1, 0, 1, 2'd1);
        vecs[13] = mk(0, 8'h00, 1, 8'h3E, 3'd1, 32'h0000003E, 0, 0, 1, 1, 1, 2'd0);
        vecs[14] = mk(1, 8'h01, 0, 8'h00, 3'd1, 32'h00000001, 0, 0, 0, 0, 1, 2'd0);
`ifdef KEY_BANK_DUP_FILTER_EN
        vecs[15] = mk(1, 8'h01, 0, 8'h00, 3'd1, 32'h00000001, 0, 0, 0, 0, 1, 2'd0);
        vecs[16] = mk(1, 8'h02, 0, 8'h00, 3'd2, 32'h00000201, 0, 0, 0, 0, 1, 2'd0);
        vecs[17] = mk(0, 8'h00, 1, 8'h02, 3'd2, 32'h00000201, 0, 0, 1, 1, 1, 2'd1);
`else
        vecs[15] = mk(1, 8'h01, 0, 8'h00, 3'd2, 32'h00000101, 0, 0, 0, 0, 1, 2'd0);
        vecs[16] = mk(1, 8'h02, 0, 8'h00, 3'd3, 32'h00020101, 0, 0, 0, 0, 1, 2'd0);
        vecs[17] = mk(0, 8'h00, 1, 8'h02, 3'd3, 32'h00020101, 0, 0, 1, 1, 1, 2'd2);
`endif

        reset_n = 1'b0;
        din = '0; kset = 1'b0; qry_din = '0; qry_valid = 1'b0;
        w_din = '0; w_kset = 1'b0; o_din = '0; o_kset = 1'b0;
        step();
        step();
        chk_all("reset", 3'd0, 32'h0, 0, 0, 0, 0, 0, 2'd0);
        reset_n = 1'b1;

        for (int r = 0; r < NVEC; r++) begin
            kset = vecs[r].kset; din = vecs[r].din;
            qry_valid = vecs[r].qv; qry_din = vecs[r].qd;
            step();
            $display("vec %0d: kset=%0d din=%02h qv=%0d qd=%02h -> num=%0d keys=%08h ovf=%0d kv=%0d mv=%0d hit=%0d idx=%0d",
                     r, kset, din, qry_valid, qry_din, num_keys, keys, overflow,
                     keys_valid, match_valid, match_hit, match_idx);
            chk_all($sformatf("vec%0d", r), vecs[r].e_num, vecs[r].e_keys, vecs[r].e_full,
                    vecs[r].e_ovf, vecs[r].e_kv, vecs[r].e_mv, vecs[r].e_mh, vecs[r].e_mi);
        end
        qry_valid = 1'b0;

        // Mid-load asynchronous reset between edges.
        kset = 1'b1; din = 8'hAA;
        step();
        din = 8'hBB;
        step();
        chk("preasync num_keys", 32'(num_keys), 32'd2);
        #3 reset_n = 1'b0;
        kset = 1'b0;
        #1;
        $display("async reset: num=%0d keys=%08h kv=%0d", num_keys, keys, keys_valid);
        chk_all("async", 3'd0, 32'h0, 0, 0, 0, 0, 0, 2'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("postasync num_keys", 32'(num_keys), 32'd0);
        chk("postasync keys_valid", 32'(keys_valid), 32'd0);

        // Ring mode: fifth write overwrites slot 0, sixth overwrites slot 1.
        w_kset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            w_din = 8'(i);
            step();
        end
        $display("wrap: num=%0d keys=%08h ovf=%0d full=%0d", w_num, w_keys, w_ovf, w_full);
        chk("wrap keys", w_keys, 32'h04030205);
        chk("wrap num_keys", 32'(w_num), 32'd4);
        chk("wrap overflow", 32'(w_ovf), 32'd1);
        chk("wrap full", 32'(w_full), 32'd1);
        w_din = 8'h06;
        step();
        $display("wrap2: num=%0d keys=%08h", w_num, w_keys);
        chk("wrap2 keys", w_keys, 32'h04030605);
        w_kset = 1'b0;
        step();
        chk("wrap keys_valid", 32'(w_kv), 32'd1);

        // Single-slot bank: full after one key, second write dropped.
        o_kset = 1'b1; o_din = 8'h11;
        step();
        $display("one1: num=%0d keys=%02h full=%0d ovf=%0d", o_num, o_keys, o_full, o_ovf);
        chk("one1 num_keys", 32'(o_num), 32'd1);
        chk("one1 full", 32'(o_full), 32'd1);
        chk("one1 overflow", 32'(o_ovf), 32'd0);
        o_din = 8'h22;
        step();
        $display("one2: num=%0d keys=%02h full=%0d ovf=%0d", o_num, o_keys, o_full, o_ovf);
        chk("one2 keys", 32'(o_keys), 32'h11);
        chk("one2 overflow", 32'(o_ovf), 32'd1);
        o_kset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
